// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 32-bit LoongArch pipeline.
// Issues loads and stores to the data memory over a req/ready handshake.
// It aligns store data to the byte lanes and extends load data. While an
// access is outstanding it holds the upstream stage with MEM_stall. Its
// results are registered toward writeback.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   MEM_*_in                 instruction from the EX/MEM register
//   dmem_req/we/addr/wstrb/wdata, dmem_ready/rdata
//                            data-memory handshake
//   MEM_stall                upstream hold
//   MEM_WB_*_out             registered results toward writeback
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | accepting; non-mem and misaligned ops finish in one cycle
// BUSY  | access outstanding, request held until dmem_ready

`ifndef PC_RST
`define PC_RST 32'h1c00_0000
`endif

module mem_stage #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MEM_valid_in,
    input  logic [31:0]   MEM_PC_in,
    input  logic [31:0]   MEM_inst_in,
    input  logic [3:0]    MEM_op_in,
    input  logic [31:0]   MEM_ALU_res_in,
    input  logic [DW-1:0] MEM_st_data_in,
    input  logic [4:0]    MEM_rd_in,
    input  logic          MEM_wen_in,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [3:0]    dmem_wstrb,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ready,
    input  logic [DW-1:0] dmem_rdata,
    output logic          MEM_stall,
    output logic          MEM_WB_valid_out,
    output logic [31:0]   MEM_WB_PC_out,
    output logic [31:0]   MEM_WB_inst_out,
    output logic [4:0]    MEM_WB_rd_out,
    output logic          MEM_WB_wen_out,
    output logic [DW-1:0] MEM_WB_wdata_out,
    output logic          MEM_WB_ale_out
);

    localparam logic [3:0] OP_LDB  = 4'd1;
    localparam logic [3:0] OP_LDH  = 4'd2;
    localparam logic [3:0] OP_LDW  = 4'd3;
    localparam logic [3:0] OP_STB  = 4'd4;
    localparam logic [3:0] OP_STH  = 4'd5;
    localparam logic [3:0] OP_STW  = 4'd6;
    localparam logic [3:0] OP_LDBU = 4'd7;
    localparam logic [3:0] OP_LDHU = 4'd8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nx;

    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [4:0]  rd_q;
    logic        wen_q;

    logic        in_mem;
    logic        in_misal;
    logic        accept;
    logic [1:0]  off;
    logic        is_store_q;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    // Decode of the incoming op
    always_comb begin
        in_mem   = (MEM_op_in >= OP_LDB) && (MEM_op_in <= OP_LDHU);
        in_misal = 1'b0;
        case (MEM_op_in)
            OP_LDH, OP_STH, OP_LDHU: in_misal = MEM_ALU_res_in[0];
            OP_LDW, OP_STW:          in_misal = |MEM_ALU_res_in[1:0];
            default:                 in_misal = 1'b0;
        endcase
        accept = MEM_valid_in && in_mem && !in_misal;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        MEM_stall = 1'b0;
        dmem_req  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    MEM_stall = 1'b1;
                    state_nx  = BUSY;
                end
            end
            BUSY: begin
                dmem_req  = 1'b1;
                // Release upstream in the completing cycle so it advances
                // on the same edge the result is registered.
                MEM_stall = !dmem_ready;
                if (dmem_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Store formatting from the latched access
    assign off        = addr_q[1:0];
    assign is_store_q = (op_q == OP_STB) || (op_q == OP_STH) || (op_q == OP_STW);
    assign dmem_addr  = AW'({addr_q[31:2], 2'b00});
    assign dmem_we    = is_store_q;

    always_comb begin
        dmem_wstrb = 4'b0000;
        dmem_wdata = '0;
        case (op_q)
            OP_STB: begin
                dmem_wstrb = 4'b0001 << off;
                dmem_wdata = {4{sdata_q[7:0]}};
            end
            OP_STH: begin
                dmem_wstrb = off[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{sdata_q[15:0]}};
            end
            OP_STW: begin
                dmem_wstrb = 4'b1111;
                dmem_wdata = sdata_q;
            end
            default: begin
                dmem_wstrb = 4'b0000;
                dmem_wdata = '0;
            end
        endcase
    end

    // Load extraction from the returned word
    always_comb begin
        byte_sel = dmem_rdata[{off, 3'b000} +: 8];
        half_sel = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (op_q)
            OP_LDB:  load_val = {{24{byte_sel[7]}}, byte_sel};
            OP_LDBU: load_val = {24'h0, byte_sel};
            OP_LDH:  load_val = {{16{half_sel[15]}}, half_sel};
            OP_LDHU: load_val = {16'h0, half_sel};
            OP_LDW:  load_val = dmem_rdata;
            default: load_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q             <= 4'd0;
            addr_q           <= 32'h0;
            sdata_q          <= 32'h0;
            pc_q             <= 32'h0;
            inst_q           <= 32'h0;
            rd_q             <= 5'd0;
            wen_q            <= 1'b0;
            MEM_WB_valid_out <= 1'b0;
            MEM_WB_PC_out    <= `PC_RST;
            MEM_WB_inst_out  <= 32'h0;
            MEM_WB_rd_out    <= 5'd0;
            MEM_WB_wen_out   <= 1'b0;
            MEM_WB_wdata_out <= '0;
            MEM_WB_ale_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!MEM_valid_in) begin
                        MEM_WB_valid_out <= 1'b0;
                        MEM_WB_wen_out   <= 1'b0;
                    end else if (!in_mem || in_misal) begin
                        MEM_WB_valid_out <= 1'b1;
                        MEM_WB_PC_out    <= MEM_PC_in;
                        MEM_WB_inst_out  <= MEM_inst_in;
                        MEM_WB_rd_out    <= MEM_rd_in;
                        MEM_WB_wen_out   <= in_mem ? 1'b0 : MEM_wen_in;
                        MEM_WB_wdata_out <= MEM_ALU_res_in;
                        MEM_WB_ale_out   <= in_mem;
                    end else begin
                        op_q             <= MEM_op_in;
                        addr_q           <= MEM_ALU_res_in;
                        sdata_q          <= MEM_st_data_in;
                        pc_q             <= MEM_PC_in;
                        inst_q           <= MEM_inst_in;
                        rd_q             <= MEM_rd_in;
                        wen_q            <= MEM_wen_in;
                        MEM_WB_valid_out <= 1'b0;
                        MEM_WB_wen_out   <= 1'b0;
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        MEM_WB_valid_out <= 1'b1;
                        MEM_WB_PC_out    <= pc_q;
                        MEM_WB_inst_out  <= inst_q;
                        MEM_WB_rd_out    <= rd_q;
                        MEM_WB_wen_out   <= is_store_q ? 1'b0 : wen_q;
                        MEM_WB_wdata_out <= is_store_q ? 32'h0 : load_val;
                        MEM_WB_ale_out   <= 1'b0;
                    end else begin
                        MEM_WB_valid_out <= 1'b0;
                        MEM_WB_wen_out   <= 1'b0;
                    end
                end
                default: begin
                    MEM_WB_valid_out <= 1'b0;
                    MEM_WB_wen_out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector bench for mem_stage. It uses a table of
// single-access vectors and a few hand-written sequences for wait states,
// reset and reset during an outstanding access.

`ifndef PC_RST
`define PC_RST 32'h1c00_0000
`endif

module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] pc, inst, alu, sdata, rdata;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wen, ready;
    logic        req, we, stall, v_o, wen_o, ale_o;
    logic [31:0] maddr, mwdata, pc_o, inst_o, wdata_o;
    logic [3:0]  wstrb;
    logic [4:0]  rd_o;

    int n_applied = 0;
    int n_err     = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .MEM_valid_in(valid), .MEM_PC_in(pc), .MEM_inst_in(inst),
        .MEM_op_in(op), .MEM_ALU_res_in(alu), .MEM_st_data_in(sdata),
        .MEM_rd_in(rd), .MEM_wen_in(wen),
        .dmem_req(req), .dmem_we(we), .dmem_addr(maddr), .dmem_wstrb(wstrb),
        .dmem_wdata(mwdata), .dmem_ready(ready), .dmem_rdata(rdata),
        .MEM_stall(stall),
        .MEM_WB_valid_out(v_o), .MEM_WB_PC_out(pc_o), .MEM_WB_inst_out(inst_o),
        .MEM_WB_rd_out(rd_o), .MEM_WB_wen_out(wen_o),
        .MEM_WB_wdata_out(wdata_o), .MEM_WB_ale_out(ale_o)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        wen;
        logic        exp_stall;
        logic [31:0] exp_maddr;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_mwdata;
        logic [31:0] exp_wdata;
        logic        exp_wen;
        logic        exp_ale;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 1'b0; op = 4'd0; alu = 32'hFFFF_FFFF; sdata = 32'h0;
        rd = 5'd0; wen = 1'b0; pc = 32'h0; inst = 32'h0;
    endtask

    localparam logic [31:0] R = 32'h80AB_CDEF;

    initial begin
        // op, addr, sdata, rdata, wen, stall, maddr, we, wstrb, mwdata, wdata, wen_o, ale
        vecs.push_back(vec_t'{4'd0, 32'h1234_5678, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h1234_5678, 1'b1, 1'b0});
        vecs.push_back(vec_t'{4'd1, 32'h1000_0003, 32'h55, R, 1'b1, 1'b1, 32'h1000_0000, 1'b0, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b0});
        vecs.push_back(vec_t'{4'd7, 32'h1000_0003, 32'h55, R, 1'b1, 1'b1, 32'h1000_0000, 1'b0, 4'h0, 32'h0, 32'h0000_0080, 1'b1, 1'b0});
        vecs.push_back(vec_t'{4'd1, 32'h1000_0000, 32'h0, R, 1'b1, 1'b1, 32'h1000_0000, 1'b0, 4'h0, 32'h0, 32'hFFFF_FFEF, 1'b1, 1'b0});
        vecs.push_back(vec_t'{4'd7, 32'h1000_0001, 32'h0, R, 1'b1, 1'b1, 32'h1000_0000, 1'b0, 4'h0, 32'h0, 32'h0000_00CD, 1'b1, 1'b0});
        vecs.push_back(vec_t'{4'd2, 32'h1000_0002, 32'h0, R, 1'b1, 1'b1, 32'h1000_0000, 1'b0, 4'h0, 32'h0, 32'hFFFF_80AB, 1'b1, 1'b0});
        vecs.push_back(vec_t'{4'd8, 32'h1000_0000, 32'h0, R, 1'b1, 1'b1, 32'h1000_0000, 1'b0, 4'h0, 32'h0, 32'h0000_CDEF, 1'b1, 1'b0});
        vecs.push_back(vec_t'{4'd2, 32'h1000_0000, 32'h0, R, 1'b1, 1'b1, 32'h1000_0000, 1'b0, 4'h0, 32'h0, 32'hFFFF_CDEF, 1'b1, 1'b0});
        vecs.push_back(vec_t'{4'd8, 32'h1000_0002, 32'h0, R, 1'b0, 1'b1, 32'h1000_0000, 1'b0, 4'h0, 32'h0, 32'h0000_80AB, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd3, 32'h0000_0100, 32'h0, R, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 4'h0, 32'h0, 32'h80AB_CDEF, 1'b1, 1'b0});
        vecs.push_back(vec_t'{4'd5, 32'h2000_0002, 32'hDEAD_BEEF, R, 1'b1, 1'b1, 32'h2000_0000, 1'b1, 4'hC, 32'hBEEF_BEEF, 32'h0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd4, 32'h2000_0011, 32'h1234_5678, R, 1'b1, 1'b1, 32'h2000_0010, 1'b1, 4'h2, 32'h7878_7878, 32'h0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd6, 32'h3000_0008, 32'hCAFE_F00D, R, 1'b1, 1'b1, 32'h3000_0008, 1'b1, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{4'd3, 32'h0000_0006, 32'h0, R, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0000_0006, 1'b0, 1'b1});
        vecs.push_back(vec_t'{4'd2, 32'h0000_0005, 32'h0, R, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0000_0005, 1'b0, 1'b1});
        vecs.push_back(vec_t'{4'd6, 32'h0000_0002, 32'h0, R, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0000_0002, 1'b0, 1'b1});
        vecs.push_back(vec_t'{4'd5, 32'h0000_0001, 32'h0, R, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0000_0001, 1'b0, 1'b1});
        vecs.push_back(vec_t'{4'd8, 32'h0000_0003, 32'h0, R, 1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0000_0003, 1'b0, 1'b1});
        vecs.push_back(vec_t'{4'd9, 32'h0000_A5A5, 32'h0, R, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0000_A5A5, 1'b0, 1'b0});

        // Reset
        idle_inputs();
        ready = 1'b0; rdata = 32'h0; rst = 1'b1;
        tick(); tick();
        chk("rst valid_out", 32'(v_o), 32'h0);
        chk("rst wen_out", 32'(wen_o), 32'h0);
        chk("rst pc_out", pc_o, `PC_RST);
        chk("rst req", 32'(req), 32'h0);
        chk("rst stall", 32'(stall), 32'h0);
        rst = 1'b0;

        // ready while idle is ignored
        ready = 1'b1;
        tick();
        chk("idle ready valid_out", 32'(v_o), 32'h0);
        chk("idle ready req", 32'(req), 32'h0);
        ready = 1'b0;

        // Table vectors
        for (int i = 0; i < vecs.size(); i++) begin
            valid = 1'b1; op = vecs[i].op; alu = vecs[i].addr;
            sdata = vecs[i].sdata; wen = vecs[i].wen;
            rd = 5'(i + 1); pc = 32'h1c00_1000 + 32'(i * 4); inst = 32'h0280_0000 | 32'(i);
            ready = 1'b0; rdata = 32'h0;
            #1;
            chk($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            chk($sformatf("v%0d idle req", i), 32'(req), 32'h0);
            tick();
            idle_inputs();
            if (vecs[i].exp_stall) begin
                chk($sformatf("v%0d busy req", i), 32'(req), 32'h1);
                chk($sformatf("v%0d maddr", i), maddr, vecs[i].exp_maddr);
                chk($sformatf("v%0d we", i), 32'(we), 32'(vecs[i].exp_we));
                chk($sformatf("v%0d wstrb", i), 32'(wstrb), 32'(vecs[i].exp_wstrb));
                if (vecs[i].exp_we)
                    chk($sformatf("v%0d mwdata", i), mwdata, vecs[i].exp_mwdata);
                chk($sformatf("v%0d bubble", i), 32'(v_o), 32'h0);
                ready = 1'b1; rdata = vecs[i].rdata;
                #1;
                chk($sformatf("v%0d done stall", i), 32'(stall), 32'h0);
                tick();
                ready = 1'b0; rdata = 32'h0;
            end
            chk($sformatf("v%0d valid_out", i), 32'(v_o), 32'h1);
            chk($sformatf("v%0d wdata_out", i), wdata_o, vecs[i].exp_wdata);
            chk($sformatf("v%0d wen_out", i), 32'(wen_o), 32'(vecs[i].exp_wen));
            chk($sformatf("v%0d ale_out", i), 32'(ale_o), 32'(vecs[i].exp_ale));
            chk($sformatf("v%0d pc_out", i), pc_o, 32'h1c00_1000 + 32'(i * 4));
            chk($sformatf("v%0d rd_out", i), 32'(rd_o), 32'(i + 1));
            chk($sformatf("v%0d inst_out", i), inst_o, 32'h0280_0000 | 32'(i));
        end

        // Loads with three wait states: stall high for four cycles in total
        for (int k = 0; k < 2; k++) begin
            int stall_cnt;
            stall_cnt = 0;
            valid = 1'b1; op = (k == 0) ? 4'd1 : 4'd7; alu = 32'h1000_0003;
            wen = 1'b1; rd = 5'd9; pc = 32'h1c00_2000; inst = 32'h2800_0000;
            ready = 1'b0; rdata = 32'h0;
            #1;
            if (stall) stall_cnt++;
            tick();
            idle_inputs();
            for (int c = 0; c < 3; c++) begin
                if (stall) stall_cnt++;
                chk($sformatf("ws%0d addr stable c%0d", k, c), maddr, 32'h1000_0000);
                chk($sformatf("ws%0d req c%0d", k, c), 32'(req), 32'h1);
                tick();
            end
            ready = 1'b1; rdata = R;
            #1;
            if (stall) stall_cnt++;
            chk($sformatf("ws%0d stall cycles", k), 32'(stall_cnt), 32'd4);
            tick();
            ready = 1'b0; rdata = 32'h0;
            chk($sformatf("ws%0d valid_out", k), 32'(v_o), 32'h1);
            chk($sformatf("ws%0d wdata_out", k), wdata_o, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            chk($sformatf("ws%0d wen_out", k), 32'(wen_o), 32'h1);
            chk($sformatf("ws%0d rd_out", k), 32'(rd_o), 32'd9);
            tick();
            chk($sformatf("ws%0d req after", k), 32'(req), 32'h0);
        end

        // Reset during an outstanding LD.W
        valid = 1'b1; op = 4'd3; alu = 32'h0000_0100; wen = 1'b1; rd = 5'd3;
        pc = 32'h1c00_3000; inst = 32'h2880_0000;
        tick();
        idle_inputs();
        chk("mrst busy1 req", 32'(req), 32'h1);
        tick();
        chk("mrst busy2 req", 32'(req), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst req dropped", 32'(req), 32'h0);
        chk("mrst stall", 32'(stall), 32'h0);
        chk("mrst valid_out", 32'(v_o), 32'h0);
        chk("mrst pc_out", pc_o, `PC_RST);
        valid = 1'b1; op = 4'd0; alu = 32'h0BAD_F00D; wen = 1'b1; rd = 5'd17;
        pc = 32'h1c00_3004; inst = 32'h0000_1234;
        #1;
        chk("mrst pass stall", 32'(stall), 32'h0);
        tick();
        idle_inputs();
        chk("mrst pass valid", 32'(v_o), 32'h1);
        chk("mrst pass wdata", wdata_o, 32'h0BAD_F00D);
        chk("mrst pass rd", 32'(rd_o), 32'd17);
        chk("mrst pass req", 32'(req), 32'h0);
        tick();
        chk("bubble after pass", 32'(v_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 32-bit LoongArch pipeline. Sits between the EX/MEM pipeline register and the MEM/WB boundary.
- Issues loads and stores to the data memory over a req/ready handshake. Performs byte-lane alignment and load extension.
- Raises a pipeline stall while an access is outstanding. Registers its results toward writeback.

Parameters:
- AW, 32, data-memory address width.
- DW, 32, data width. Fixed at 32; other values are unsupported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- MEM_valid_in  in  1  instruction present in stage
- MEM_PC_in  in  32  instruction PC
- MEM_inst_in  in  32  instruction word
- MEM_op_in  in  4  0 none, 1 LD.B, 2 LD.H, 3 LD.W, 4 ST.B, 5 ST.H, 6 ST.W, 7 LD.BU, 8 LD.HU; others treated as none
- MEM_ALU_res_in  in  32  effective address (mem op) or ALU result (non-mem op)
- MEM_st_data_in  in  32  store source register value
- MEM_rd_in  in  5  destination register
- MEM_wen_in  in  1  register write enable
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  AW  word-aligned address, bits [1:0] = 0
- dmem_wstrb  out  4  byte write strobes
- dmem_wdata  out  32  lane-replicated store data
- dmem_ready  in  1  request accepted/completed this cycle; rdata valid for loads
- dmem_rdata  in  32  load word
- MEM_stall  out  1  hold upstream (EX/MEM must not advance)
- MEM_WB_valid_out  out  1
- MEM_WB_PC_out  out  32
- MEM_WB_inst_out  out  32
- MEM_WB_rd_out  out  5
- MEM_WB_wen_out  out  1
- MEM_WB_wdata_out  out  32
- MEM_WB_ale_out  out  1  address-misalignment exception flag

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE.
  - All MEM_WB_* outputs 0, except MEM_WB_PC_out = `PC_RST.
  - dmem_req=0; MEM_stall=0 from the next cycle.
  - rst overrides every other input.
- Alignment checks:
  - Halfword ops (2, 5, 8) misaligned when addr[0]=1.
  - Word ops (3, 6) misaligned when addr[1:0] != 0.
  - Byte ops never misaligned.
- FSM states: IDLE, BUSY.
- IDLE, valid=0: next edge registers a bubble (valid_out=0, wen_out=0); other outputs hold.
- IDLE, valid with op none: 1-cycle pass-through.
  - Next edge: valid_out=1, wdata_out=ALU_res, wen_out=wen_in, ale_out=0. PC, inst and rd are copied.
  - MEM_stall=0.
- IDLE, valid with misaligned mem op: 1-cycle.
  - No dmem_req.
  - valid_out=1, ale_out=1, wen_out=0, wdata_out=address.
  - MEM_stall=0.
- IDLE, valid with aligned mem op:
  - MEM_stall=1 combinationally this cycle.
  - Next edge: latch op, address, store data, PC, inst, rd and wen; go to BUSY; register a bubble toward WB.
- BUSY:
  - dmem_req=1, with addr/we/wstrb/wdata driven from latched values, stable until dmem_ready.
  - MEM_stall=1 while dmem_ready=0.
  - Inputs are ignored.
- BUSY with dmem_ready=1:
  - MEM_stall=0 in that same cycle, so upstream advances at this edge.
  - Next edge: valid_out=1 and ale_out=0.
  - Loads: wen_out=latched wen, wdata_out=extracted value.
  - Stores: wen_out=0, wdata_out=0.
  - State returns to IDLE.
  - Minimum mem-op occupancy is 2 cycles; each extra cycle without ready adds 1.
- Store formatting (off = addr[1:0]):
  - ST.B: wstrb = 4'b0001 << off; wdata = {4{data[7:0]}}.
  - ST.H: wstrb = 0011 if off=0, 1100 if off=2; wdata = {2{data[15:0]}}.
  - ST.W: wstrb = 1111; wdata = data.
  - Loads: we=0, wstrb=0000.
- Load extraction:
  - Select byte rdata[8*off +: 8], or halfword rdata[16*off[1] +: 16].
  - LD.B/LD.H sign-extend; LD.BU/LD.HU zero-extend; LD.W uses the full word.
- dmem_ready in IDLE is ignored.
- rst asserted while BUSY: dmem_req drops the next cycle and the access is abandoned. The memory side must tolerate a dropped request.
- No flush input. Once accepted, an access always completes.

Test Plan:
- Reset: rst=1 for 2 cycles → valid_out=0, wen_out=0, PC_out=`PC_RST, dmem_req=0, stall=0.
- Pass-through ALU: op=0, ALU_res=0x1234_5678, rd=5, wen=1 → one cycle later valid_out=1, wdata_out=0x12345678, rd_out=5; stall never asserted.
- LD.B with wait states: addr=0x1000_0003, ready held 0 for 3 BUSY cycles then 1, rdata=0x80AB_CDEF.
  - stall high for 4 cycles in total.
  - wdata_out=0xFFFF_FF80, wen_out=1.
  - Repeat with LD.BU → 0x0000_0080.
- ST.H: addr=0x2000_0002, data=0xDEAD_BEEF, ready on the first BUSY cycle → dmem_addr=0x2000_0000, wstrb=1100, wdata=0xBEEF_BEEF, we=1; WB wen_out=0.
- Misaligned LD.W: addr=0x0000_0006 → no dmem_req, ale_out=1, wen_out=0, stall=0.
- Reset mid-BUSY: LD.W at 0x100, rst pulsed on the second BUSY cycle → dmem_req=0 next cycle, state IDLE, valid_out=0; a subsequent op=0 instruction passes normally.
